// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data memory responder.
// State encoding and width/depth defaults live here.
package dmem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 4096;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core and the data memory.
// master = processor side, slave = responder side.
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous write, registered read.
// Contents are never cleared by reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write and registered read share the one address port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: write in one cycle, read after RD_LAT cycles.
// Optional macro DMEM_ERR_EN adds an out-of-range err pulse output.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
`ifdef DMEM_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              rd_ok;
  logic              in_rng;
  logic              acc;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  assign acc      = bus.req_valid && bus.req_ready;
  assign ram_addr = (state == IDLE) ? bus.req_addr : addr_q;
  assign in_rng   = ({1'b0, ram_addr} < LIM);
  assign ram_we   = acc && bus.req_we && in_rng;

  // the array is read once, on the edge that enters RSP,
  // so any write accepted earlier is already stored
  assign ram_re   = (state != RSP) && (state_n == RSP);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_rdata = (state == RSP && rd_ok) ? ram_q : '0;

  // next-state and latency counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (acc && !bus.req_we) begin
          if (RD_LAT == 1) begin
            state_n = RSP;
          end else begin
            state_n = RD_WAIT;
            cnt_n   = 4'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, counter, read address and range flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      rd_ok  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (acc && !bus.req_we) addr_q <= bus.req_addr;
      if (ram_re) rd_ok <= in_rng;
    end
  end

`ifdef DMEM_ERR_EN
  // one-cycle pulse after any accepted out-of-range request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= acc && !in_rng;
  end
`endif

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr[AW-1:0]),
    .wdata (bus.req_wdata),
    .rdata (ram_q)
  );

endmodule
